// File: rtl/cw305_reg_pkg.sv
// cw305_reg_pkg: register indices, field positions and default ID for the CW305 USB register bridge.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cw305_reg_pkg;

   // Register indices (upper address bits)
   localparam int REG_ID        = 0;
   localparam int REG_LEDS      = 1;
   localparam int REG_STATUS    = 2;
   localparam int REG_KEY       = 3;
   localparam int REG_TEXTIN    = 4;
   localparam int REG_CIPHEROUT = 5;

   localparam logic [7:0] DEFAULT_ID = 8'h2E;

   // STATUS fields: busy/done on read, go on write
   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;
   localparam int STATUS_GO_BIT   = 0;

   // LEDS fields
   localparam int LEDS_W   = 3;
   localparam int LED1_BIT = 2;
   localparam int LED2_BIT = 1;
   localparam int LED3_BIT = 0;

endpackage

// File: rtl/cw305_edge_detect.sv
// cw305_edge_detect: 2-flop synchroniser followed by a one-cycle rising or falling edge pulse.
// Latency: pulse appears 2 clocks after the input change is first sampled.
// Backpressure: none.
// Ports: clk_i, rst_i (async active-high), sig_i (asynchronous level), edge_o (one-cycle pulse).
// FALLING=1 selects falling-edge detection, otherwise rising.
module cw305_edge_detect #(
   parameter bit FALLING = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic edge_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Flops clear to 0: a strobe already held low through reset looks like
   // "was always low", so no spurious falling edge is seen afterwards.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= sig_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign edge_o = FALLING ? (prev_q & ~sync_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/cw305_reg_bridge.sv
// cw305_reg_bridge: byte-wide USB register bridge (ID/LEDS/STATUS/KEY/TEXTIN/CIPHEROUT) to a crypto core.
// Latency: read data 1 clock after rdn/cen sampled low; writes commit 3 clocks after wrn falls; go 1 clock after request.
// Backpressure: none; starts while busy or with a go pending are dropped, KEY/TEXTIN writes while busy are ignored.
// Ports: usb_clk/reset_i (async active-high); usb_addr/usb_din/usb_dout/usb_isout/usb_rdn/usb_wrn/usb_cen bus;
//        usb_trigger start input; crypt_key/crypt_textin/crypt_go to core; crypt_busy/crypt_done/crypt_cipherout from core;
//        led1..led3. Define CW305_REG_HEARTBEAT_EN to drive led3 from a free-running heartbeat counter MSB.
module cw305_reg_bridge #(
   parameter int         pADDR_WIDTH   = 21,
   parameter int         pBYTECNT_BITS = 7,
   parameter int         pCRYPT_WIDTH  = 128,
   parameter logic [7:0] pID           = cw305_reg_pkg::DEFAULT_ID,
   parameter int         pHB_BITS      = 23
) (
   input  logic                    usb_clk,
   input  logic                    reset_i,
   input  logic [pADDR_WIDTH-1:0]  usb_addr,
   input  logic [7:0]              usb_din,
   output logic [7:0]              usb_dout,
   output logic                    usb_isout,
   input  logic                    usb_rdn,
   input  logic                    usb_wrn,
   input  logic                    usb_cen,
   input  logic                    usb_trigger,
   output logic [pCRYPT_WIDTH-1:0] crypt_key,
   output logic [pCRYPT_WIDTH-1:0] crypt_textin,
   output logic                    crypt_go,
   input  logic                    crypt_busy,
   input  logic                    crypt_done,
   input  logic [pCRYPT_WIDTH-1:0] crypt_cipherout,
   output logic                    led1,
   output logic                    led2,
   output logic                    led3
);
   import cw305_reg_pkg::*;

   localparam int NBYTES = pCRYPT_WIDTH / 8;

   int reg_sel;
   int byte_sel;
   assign reg_sel  = int'(usb_addr[pADDR_WIDTH-1:pBYTECNT_BITS]);
   assign byte_sel = int'(usb_addr[pBYTECNT_BITS-1:0]);

   logic [LEDS_W-1:0]       leds_q,   leds_d;
   logic [pCRYPT_WIDTH-1:0] key_q,    key_d;
   logic [pCRYPT_WIDTH-1:0] text_q,   text_d;
   logic [pCRYPT_WIDTH-1:0] cipher_q, cipher_d;
   logic                    done_q,   done_d;
   logic                    go_q,     go_d;
   logic [7:0]              dout_q,   dout_d;
   logic                    isout_q,  isout_d;

   logic wr_fall;
   logic trig_rise;

   // Chip enable is folded into the strobe so one falling edge means one
   // access with both wrn and cen low.
   cw305_edge_detect #(.FALLING(1'b1)) u_wr_edge (
      .clk_i  (usb_clk),
      .rst_i  (reset_i),
      .sig_i  (usb_wrn | usb_cen),
      .edge_o (wr_fall)
   );

   cw305_edge_detect #(.FALLING(1'b0)) u_trig_edge (
      .clk_i  (usb_clk),
      .rst_i  (reset_i),
      .sig_i  (usb_trigger),
      .edge_o (trig_rise)
   );

   logic       rd_act;
   logic       byte0;
   logic       start_req;
   logic [7:0] rdata;
   logic [7:0] key_byte, text_byte, cipher_byte;

   assign rd_act    = ~usb_rdn & ~usb_cen;
   assign byte0     = (byte_sel == 0);
   assign start_req = trig_rise |
                      (wr_fall && reg_sel == REG_STATUS && byte0 && usb_din[STATUS_GO_BIT]);

   // Read mux; out-of-range byte indices never match the loop and read 0.
   always_comb begin
      key_byte    = 8'h00;
      text_byte   = 8'h00;
      cipher_byte = 8'h00;
      for (int b = 0; b < NBYTES; b++) begin
         if (b == byte_sel) begin
            key_byte    = key_q[8*b +: 8];
            text_byte   = text_q[8*b +: 8];
            cipher_byte = cipher_q[8*b +: 8];
         end
      end
      rdata = 8'h00;
      case (reg_sel)
         REG_ID:        if (byte0) rdata = pID;
         REG_LEDS:      if (byte0) rdata = {{(8-LEDS_W){1'b0}}, leds_q};
         REG_STATUS: begin
            if (byte0) begin
               rdata[STATUS_BUSY_BIT] = crypt_busy;
               rdata[STATUS_DONE_BIT] = done_q;
            end
         end
         REG_KEY:       rdata = key_byte;
         REG_TEXTIN:    rdata = text_byte;
         REG_CIPHEROUT: rdata = cipher_byte;
         default:       rdata = 8'h00;
      endcase
   end

   always_comb begin
      leds_d   = leds_q;
      key_d    = key_q;
      text_d   = text_q;
      cipher_d = cipher_q;
      done_d   = done_q;
      isout_d  = rd_act;
      dout_d   = rd_act ? rdata : 8'h00;

      if (wr_fall && reg_sel == REG_LEDS && byte0)
         leds_d = usb_din[LEDS_W-1:0];

      if (wr_fall && !crypt_busy) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (b == byte_sel) begin
               if (reg_sel == REG_KEY)    key_d[8*b +: 8]  = usb_din;
               if (reg_sel == REG_TEXTIN) text_d[8*b +: 8] = usb_din;
            end
         end
      end

      // A USB start and a trigger in the same cycle merge into one request;
      // requests while busy or with go already high are dropped.
      go_d = start_req & ~crypt_busy & ~go_q;

      if (crypt_done) begin
         cipher_d = crypt_cipherout;
         done_d   = 1'b1;
      end
      // Issuing go wins over a coincident done: result captured, flag cleared.
      if (go_q)
         done_d = 1'b0;
   end

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         leds_q   <= '0;
         key_q    <= '0;
         text_q   <= '0;
         cipher_q <= '0;
         done_q   <= 1'b0;
         go_q     <= 1'b0;
         dout_q   <= 8'h00;
         isout_q  <= 1'b0;
      end else begin
         leds_q   <= leds_d;
         key_q    <= key_d;
         text_q   <= text_d;
         cipher_q <= cipher_d;
         done_q   <= done_d;
         go_q     <= go_d;
         dout_q   <= dout_d;
         isout_q  <= isout_d;
      end
   end

   assign usb_dout     = dout_q;
   assign usb_isout    = isout_q;
   assign crypt_key    = key_q;
   assign crypt_textin = text_q;
   assign crypt_go     = go_q;
   assign led1         = leds_q[LED1_BIT];
   assign led2         = leds_q[LED2_BIT];

`ifdef CW305_REG_HEARTBEAT_EN
   logic [pHB_BITS-1:0] hb_q;

   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) hb_q <= '0;
      else         hb_q <= hb_q + {{(pHB_BITS-1){1'b0}}, 1'b1};
   end

   assign led3 = hb_q[pHB_BITS-1];
`else
   assign led3 = leds_q[LED3_BIT];
`endif

endmodule

// File: tb/tb_cw305_reg_bridge.sv
module tb_cw305_reg_bridge;
   localparam int AW = 21;
   localparam int BB = 7;
   localparam int CW = 128;
   localparam int NB = CW / 8;

   logic          usb_clk = 1'b0;
   logic          reset_i;
   logic [AW-1:0] usb_addr;
   logic [7:0]    usb_din;
   logic [7:0]    usb_dout;
   logic          usb_isout;
   logic          usb_rdn, usb_wrn, usb_cen, usb_trigger;
   logic [CW-1:0] crypt_key, crypt_textin, crypt_cipherout;
   logic          crypt_go, crypt_busy, crypt_done;
   logic          led1, led2, led3;

   always #5 usb_clk = ~usb_clk;

   cw305_reg_bridge dut (
      .usb_clk         (usb_clk),
      .reset_i         (reset_i),
      .usb_addr        (usb_addr),
      .usb_din         (usb_din),
      .usb_dout        (usb_dout),
      .usb_isout       (usb_isout),
      .usb_rdn         (usb_rdn),
      .usb_wrn         (usb_wrn),
      .usb_cen         (usb_cen),
      .usb_trigger     (usb_trigger),
      .crypt_key       (crypt_key),
      .crypt_textin    (crypt_textin),
      .crypt_go        (crypt_go),
      .crypt_busy      (crypt_busy),
      .crypt_done      (crypt_done),
      .crypt_cipherout (crypt_cipherout),
      .led1            (led1),
      .led2            (led2),
      .led3            (led3)
   );

   int total = 0;
   int bad   = 0;
   int go_cnt = 0;

   // Count every clock in which crypt_go is high; one pulse = one count.
   always @(posedge usb_clk) if (crypt_go === 1'b1) go_cnt++;

   // Reference model: plain byte arrays and flags.
   logic [7:0] m_key  [NB];
   logic [7:0] m_text [NB];
   logic [7:0] m_ciph [NB];
   logic [2:0] m_leds;
   logic       m_done;

   task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CW-1:0] pack(input logic [7:0] a [NB]);
      logic [CW-1:0] v;
      v = '0;
      for (int i = 0; i < NB; i++) v = v | (CW'(a[i]) << (8*i));
      return v;
   endfunction

   function automatic logic [AW-1:0] mk(input int r, input int b);
      logic [AW-1:0] a;
      a = AW'(r * (1 << BB) + b);
      return a;
   endfunction

   task automatic wr(input int r, input int b, input logic [7:0] d);
      @(negedge usb_clk);
      usb_addr = mk(r, b); usb_din = d; usb_cen = 1'b0; usb_wrn = 1'b0;
      repeat (5) @(negedge usb_clk);
      usb_wrn = 1'b1; usb_cen = 1'b1;
      repeat (4) @(negedge usb_clk);
   endtask

   task automatic rd(input int r, input int b, output logic [7:0] d, output logic io);
      @(negedge usb_clk);
      usb_addr = mk(r, b); usb_cen = 1'b0; usb_rdn = 1'b0;
      @(negedge usb_clk);
      d = usb_dout; io = usb_isout;
      usb_rdn = 1'b1; usb_cen = 1'b1;
      @(negedge usb_clk);
   endtask

   initial begin
      logic [7:0]    d, v;
      logic          io, seen;
      int            b, g0;
      logic [CW-1:0] ct, snap;

      reset_i = 1'b1; usb_addr = '0; usb_din = 8'h00;
      usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen = 1'b1; usb_trigger = 1'b0;
      crypt_busy = 1'b0; crypt_done = 1'b0; crypt_cipherout = '0;
      m_leds = 3'd0; m_done = 1'b0;
      for (int i = 0; i < NB; i++) begin m_key[i] = 8'h00; m_text[i] = 8'h00; m_ciph[i] = 8'h00; end

      repeat (3) @(negedge usb_clk);
      chk("rst_dout",  CW'(usb_dout),  '0);
      chk("rst_isout", CW'(usb_isout), '0);
      chk("rst_go",    CW'(crypt_go),  '0);
      chk("rst_key",   crypt_key,      '0);
      reset_i = 1'b0;
      repeat (2) @(negedge usb_clk);

      // ID register
      rd(0, 0, d, io);
      chk("id_data",  CW'(d),  CW'(8'h2E));
      chk("id_isout", CW'(io), CW'(1'b1));
      chk("idle_isout", CW'(usb_isout), '0);

      // LEDS, strobe held 5 cycles
      wr(1, 0, 8'h05); m_leds = 3'd5;
      chk("led1", CW'(led1), CW'(m_leds[2]));
      chk("led2", CW'(led2), CW'(m_leds[1]));
`ifndef CW305_REG_HEARTBEAT_EN
      chk("led3", CW'(led3), CW'(m_leds[0]));
`endif
      for (int i = 0; i < 3; i++) begin
         v = 8'($urandom_range(0, 7));
         wr(1, 0, v); m_leds = v[2:0];
         chk("led_rand", CW'({led1, led2}), CW'({m_leds[2], m_leds[1]}));
         rd(1, 0, d, io);
         chk("leds_rd", CW'(d), CW'({5'b0, m_leds}));
      end

      // KEY / TEXTIN loads
      wr(3, 0, 8'hAA);  m_key[0]  = 8'hAA;
      wr(3, 15, 8'h55); m_key[15] = 8'h55;
      for (int i = 0; i < 4; i++) begin
         b = $urandom_range(1, 14); v = 8'($urandom);
         wr(3, b, v); m_key[b] = v;
         b = $urandom_range(0, NB-1); v = 8'($urandom);
         wr(4, b, v); m_text[b] = v;
      end
      chk("key_lsb", CW'(crypt_key[7:0]),     CW'(8'hAA));
      chk("key_msb", CW'(crypt_key[127:120]), CW'(8'h55));
      chk("key_all", crypt_key,    pack(m_key));
      chk("text_all", crypt_textin, pack(m_text));
      b = $urandom_range(0, NB-1);
      rd(3, b, d, io);
      chk("key_rd", CW'(d), CW'(m_key[b]));

      // Start via STATUS, then core busy
      g0 = go_cnt;
      wr(2, 0, 8'h01);
      chk("go_once", CW'(go_cnt - g0), CW'(1));
      crypt_busy = 1'b1;
      rd(2, 0, d, io);
      chk("status_busy", CW'(d), CW'({6'b0, m_done, 1'b1}));

      // While busy: loads ignored, starts dropped
      snap = crypt_textin;
      g0 = go_cnt;
      wr(4, 0, 8'hFF);
      wr(3, 1, ~m_key[1]);
      wr(2, 0, 8'h01);
      @(negedge usb_clk); usb_trigger = 1'b1;
      repeat (5) @(negedge usb_clk); usb_trigger = 1'b0;
      repeat (4) @(negedge usb_clk);
      chk("busy_text", crypt_textin, snap);
      chk("busy_key",  crypt_key, pack(m_key));
      chk("busy_nogo", CW'(go_cnt - g0), CW'(0));

      // Completion
      ct = 128'h0123456789ABCDEF0123456789ABCDEF;
      crypt_cipherout = ct; crypt_busy = 1'b0; crypt_done = 1'b1;
      @(negedge usb_clk); crypt_done = 1'b0;
      for (int i = 0; i < NB; i++) m_ciph[i] = ct[8*i +: 8];
      m_done = 1'b1;
      rd(5, 0, d, io);
      chk("ciph_b0", CW'(d), CW'(8'hEF));
      b = $urandom_range(0, NB-1);
      rd(5, b, d, io);
      chk("ciph_rand", CW'(d), CW'(m_ciph[b]));
      rd(2, 0, d, io);
      chk("status_done", CW'(d), CW'({6'b0, m_done, 1'b0}));

      // Trigger start with crypt_done landing in the go cycle
      g0 = go_cnt; seen = 1'b0;
      @(negedge usb_clk); usb_trigger = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge usb_clk);
         if (crypt_go === 1'b1) seen = 1'b1;
      end
      chk("go_wait", CW'(seen), CW'(1'b1));
      ct = {$urandom, $urandom, $urandom, $urandom};
      crypt_cipherout = ct; crypt_done = 1'b1;
      @(negedge usb_clk); crypt_done = 1'b0; usb_trigger = 1'b0;
      for (int i = 0; i < NB; i++) m_ciph[i] = ct[8*i +: 8];
      m_done = 1'b0;
      chk("trig_go_once", CW'(go_cnt - g0), CW'(1));
      rd(2, 0, d, io);
      chk("status_coinc", CW'(d), CW'({6'b0, m_done, 1'b0}));
      b = $urandom_range(0, NB-1);
      rd(5, b, d, io);
      chk("ciph_coinc", CW'(d), CW'(m_ciph[b]));

      // USB start and trigger together -> one go
      repeat (3) @(negedge usb_clk);
      g0 = go_cnt;
      usb_addr = mk(2, 0); usb_din = 8'h01; usb_cen = 1'b0; usb_wrn = 1'b0; usb_trigger = 1'b1;
      repeat (5) @(negedge usb_clk);
      usb_wrn = 1'b1; usb_cen = 1'b1; usb_trigger = 1'b0;
      repeat (4) @(negedge usb_clk);
      chk("dual_go_once", CW'(go_cnt - g0), CW'(1));

      // Undefined register, RO writes, out-of-range byte
      rd(9, 0, d, io);
      chk("undef_rd", CW'(d), '0);
      wr(0, 0, 8'h11);
      rd(0, 0, d, io);
      chk("id_ro", CW'(d), CW'(8'h2E));
      wr(5, 0, ~m_ciph[0]);
      rd(5, 0, d, io);
      chk("ciph_ro", CW'(d), CW'(m_ciph[0]));
      rd(3, 20, d, io);
      chk("key_b20", CW'(d), '0);

      // Reset in the middle of a write
      wr(1, 0, 8'h07); m_leds = 3'd7;
      @(negedge usb_clk);
      usb_addr = mk(1, 0); usb_din = 8'h02; usb_cen = 1'b0; usb_wrn = 1'b0;
      @(negedge usb_clk);
      #1 reset_i = 1'b1;
      #1;
      chk("mid_rst_dout", CW'(usb_dout), '0);
      chk("mid_rst_io",   CW'(usb_isout), '0);
      chk("mid_rst_go",   CW'(crypt_go), '0);
      chk("mid_rst_key",  crypt_key, '0);
      chk("mid_rst_text", crypt_textin, '0);
      chk("mid_rst_leds", CW'({led1, led2, led3}), '0);
      @(negedge usb_clk); reset_i = 1'b0;
      m_leds = 3'd0;
      repeat (6) @(negedge usb_clk);
      usb_wrn = 1'b1; usb_cen = 1'b1;
      repeat (4) @(negedge usb_clk);
      chk("post_rst_leds", CW'({led1, led2}), '0);
      rd(1, 0, d, io);
      chk("post_rst_rd", CW'(d), CW'({5'b0, m_leds}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cw305_reg_bridge.md
CW305_REG_BRIDGE -- requirements
Module: cw305_reg_bridge

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 21: USB address width.
REQ-002 SHALL have parameter pBYTECNT_BITS, default 7: low address bits used as byte index within a register.
REQ-003 SHALL have parameter pCRYPT_WIDTH, default 128: key/text width in bits, multiple of 8, at most 8*2^pBYTECNT_BITS.
REQ-004 SHALL have parameter pID, default 8'h2E: identifier byte.
REQ-005 SHALL have parameter pHB_BITS, default 23: heartbeat counter width.
REQ-006 SHALL have these ports (name, direction, width, meaning):
- usb_clk  in  1  sole clock.
- reset_i  in  1  reset, asynchronous, active-high.
- usb_addr  in  pADDR_WIDTH  register/byte address.
- usb_din  in  8  write data.
- usb_dout  out  8  read data.
- usb_isout  out  1  high while the bridge drives the data bus.
- usb_rdn, usb_wrn, usb_cen  in  1 each  active-low read, write, chip enable.
- usb_trigger  in  1  external start request.
- crypt_key, crypt_textin  out  pCRYPT_WIDTH  operands to core.
- crypt_go  out  1  one-cycle start pulse.
- crypt_busy, crypt_done  in  1 each  core busy level; one-cycle completion pulse.
- crypt_cipherout  in  pCRYPT_WIDTH  core result.
- led1, led2, led3  out  1 each  LEDs.

Function
REQ-007 SHALL decode register index = usb_addr[pADDR_WIDTH-1:pBYTECNT_BITS] and byte index = usb_addr[pBYTECNT_BITS-1:0]; byte 0 is the LSB of wide registers.
REQ-008 SHALL implement this register map:
- 0 ID: RO, returns pID.
- 1 LEDS: RW, bits [2:0].
- 2 STATUS: read {6'b0, done_flag, crypt_busy}; write with bit0=1 requests start.
- 3 KEY: RW.
- 4 TEXTIN: RW.
- 5 CIPHEROUT: RO.
REQ-009 SHALL return 8'h00 for reads of an undefined register or a byte index >= pCRYPT_WIDTH/8, and SHALL ignore writes to them and to RO registers.
REQ-010 SHALL register usb_dout one cycle after usb_rdn and usb_cen are sampled low, and SHALL assert usb_isout in the same cycle as that data, while both stay low.
REQ-011 SHALL perform exactly one write per strobe, on the first cycle usb_wrn and usb_cen are both sampled low (falling-edge detect).
REQ-012 SHALL ignore KEY and TEXTIN writes while crypt_busy=1.
REQ-013 SHALL pulse crypt_go for one cycle, the cycle after a start request, only when crypt_busy=0 and no go is pending; a request while busy SHALL be dropped.
REQ-014 SHALL treat a rising edge of usb_trigger (synchronised through 2 flops) as a start request; a USB request and a trigger in the same cycle SHALL produce one go pulse.
REQ-015 SHALL capture crypt_cipherout into CIPHEROUT and set done_flag on crypt_done.
REQ-016 SHALL clear done_flag when crypt_go is issued; if crypt_done and crypt_go coincide, the capture SHALL still occur and done_flag SHALL end cleared.
REQ-017 SHALL drive led1=LEDS[2] and led2=LEDS[1]; led3 per REQ-021.

Reset
REQ-018 SHALL clear on reset_i, without waiting for a clock: LEDS, KEY, TEXTIN, CIPHEROUT, done_flag, edge detectors, synchronisers and heartbeat counter, giving usb_dout=0, usb_isout=0 and crypt_go=0.
REQ-019 SHALL abort a read or write in progress when reset asserts, with no write committed after reset deasserts until a new falling edge.

Configuration
REQ-020 SHALL provide macro CW305_REG_HEARTBEAT_EN.
REQ-021 With the macro defined, led3 SHALL be the MSB of a free-running pHB_BITS counter; without it, led3 SHALL equal LEDS[0] and no counter SHALL exist.

Structure
REQ-022 SHALL take register index constants, field positions and the default ID from shared package cw305_reg_pkg.
REQ-023 SHALL use one sub-module, cw305_edge_detect (2-flop synchroniser plus rising/falling pulse), for the usb_wrn and usb_trigger edges.

Verification
REQ-024 Read reg 0 byte 0 -> usb_dout=8'h2E one cycle later, usb_isout=1.
REQ-025 Write 8'h05 to LEDS, hold usb_wrn low 5 cycles -> exactly one write; led1=1, led2=0, led3=1 (macro undefined).
REQ-026 Write KEY byte 0=8'hAA and byte 15=8'h55, issue start -> crypt_key[7:0]=8'hAA, crypt_key[127:120]=8'h55, one crypt_go pulse; STATUS byte 0 reads 8'h01 while busy.
REQ-027 While busy, write TEXTIN=8'hFF and start again -> TEXTIN unchanged, no second crypt_go.
REQ-028 crypt_done with cipherout=128'h0123..EF -> CIPHEROUT byte 0 reads 8'hEF, STATUS byte 0 reads 8'h02; assert crypt_done and crypt_go in the same cycle -> captured, done_flag=0.
REQ-029 Assert reset_i mid-write with no clock edge -> all outputs 0 immediately; byte-index 20 read -> 8'h00.
